// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
`default_nettype none

package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder.sv
// 1-bit full adder cell shared by the serial datapath.
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: sequences one full_adder LSB-first over WIDTH cycles
// behind valid/ready handshakes on both operand and result sides.
`default_nettype none

module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_next;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            cnt      <= '0;
            sum_sr   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_sr <= sum_next;
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          carry  <= fa_carry;
          // On the MSB step, 'carry' still holds the carry into the MSB.
          if (cnt == CNT_LAST) begin
            sum       <= sum_next;
            cout      <= fa_carry;
            ovf       <= carry ^ fa_carry;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 directed, WIDTH=2 sweep).
`default_nettype none

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       in_valid = 1'b0, in_ready, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic       out_valid, out_ready = 1'b1, cout, ovf, busy;

  logic       in_valid2 = 1'b0, in_ready2, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       out_valid2, out_ready2 = 1'b1, cout2, ovf2, busy2;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Drive one WIDTH=8 operation; called at a negedge, returns at a negedge.
  task automatic txn8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input bit check_lat, input bit inject);
    int   tries;
    int   cycles;
    int   busy_cnt;
    exp_t e;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      timeout("accept");
      in_valid = 1'b0;
      return;
    end
    sbq.push_back('{es, ec, eo});
    cycles = 0;
    busy_cnt = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && cycles < 40) begin
      if (busy) busy_cnt++;
      if (inject && cycles == 2) begin
        a = 8'hAA; b = 8'h55; in_valid = 1'b1;
      end
      if (inject && cycles == 5) in_valid = 1'b0;
      cycles++;
      @(negedge clk);
    end
    if (!out_valid) begin
      timeout("result");
      return;
    end
    if (check_lat) begin
      chk("latency", 64'(cycles), 64'd8);
      chk("busy_cycles", 64'(busy_cnt), 64'd8);
    end
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 64'(sbq.size()), 64'd1);
      return;
    end
    e = sbq.pop_front();
    chk("sum", 64'(sum), 64'(e.s));
    chk("cout", 64'(cout), 64'(e.c));
    chk("ovf", 64'(ovf), 64'(e.o));
    if (out_ready) @(negedge clk);
  endtask

  task automatic txn2(input logic [1:0] ta, input logic [1:0] tb, input logic tc);
    int   tries;
    int   sa, sb, sv, tot;
    exp_t e;
    tot = int'(ta) + int'(tb) + int'(tc);
    sa  = (ta >= 2) ? int'(ta) - 4 : int'(ta);
    sb  = (tb >= 2) ? int'(tb) - 4 : int'(tb);
    sv  = sa + sb + int'(tc);
    a2 = ta; b2 = tb; cin2 = tc; in_valid2 = 1'b1;
    tries = 0;
    while (!in_ready2 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready2) begin
      timeout("accept2");
      in_valid2 = 1'b0;
      return;
    end
    sbq.push_back('{8'(tot & 3), tot[2], (sv > 1) || (sv < -2)});
    @(negedge clk);
    in_valid2 = 1'b0;
    tries = 0;
    while (!out_valid2 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!out_valid2) begin
      timeout("result2");
      return;
    end
    e = sbq.pop_front();
    chk($sformatf("sweep_%0d_%0d_%0d", ta, tb, tc),
        64'({sum2, cout2, ovf2}), 64'({e.s[1:0], e.c, e.o}));
    @(negedge clk);
  endtask

  initial begin
    int spurious;
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    vecs[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

    rst = 1'b1;
    #12;
    chk("rst_state", 64'({out_valid, busy, in_ready, sum, cout, ovf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++)
      txn8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o, i == 0, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    txn8(8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", 64'({out_valid, in_ready, sum, cout, ovf}), 64'({1'b1, 1'b0, 8'h46, 1'b0, 1'b0}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

    // Operands offered during RUN are ignored.
    txn8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    spurious = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    chk("single_result", 64'(spurious), 64'd0);
    chk("queue_drained", 64'(sbq.size()), 64'd0);

    // Asynchronous abort in the middle of RUN.
    a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", 64'({out_valid, busy, in_ready, sum, cout, ovf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          txn2(2'(ia), 2'(ib), 1'(ic));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
